// File: rtl/gpio_expander_regfile.sv
// ---------------------------------------------------------------------------
// gpio_expander_regfile
//
// Register file and pin interface for an I2C-addressed GPIO expander with
// NUM_PORTS 8-bit ports. It sits behind an I2C slave byte engine and in front
// of the device pins. It adds input synchronisation, polarity inversion,
// per-bit change detection with mask and sticky status, and an active-low
// interrupt. With NUM_PORTS=2, addresses 0x00-0x07 follow the TCA9539 layout.
//
// Register map (N = NUM_PORTS, p = port index):
//   p      input[p]    (read-only, sync ^ polarity)
//   N+p    output[p]
//   2N+p   polarity[p]
//   3N+p   config[p]   (1 = input, 0 = output)
//   4N+p   mask[p]     (1 = masked)
//   5N+p   status[p]   (read-only, sticky, cleared by a read strobe at p)
//   >= 6N  unmapped    (reads 0x00, writes ignored)
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   addr      in   [7:0] register address
//   dataIn    in   [7:0] write data
//   writeEn   in   one-cycle write strobe
//   rdStrobe  in   one-cycle "byte at addr went to the master" strobe
//   dataOut   out  [7:0] registered read data, valid one cycle after addr
//   gpio_in   in   [8N-1:0] raw asynchronous pin inputs
//   gpio_out  out  [8N-1:0] output-port register
//   gpio_oe   out  [8N-1:0] pin drive enable (~config)
//   int_n     out  registered interrupt, active low
//
// Strobe semantics: writeEn and rdStrobe are single-cycle qualifiers sampled
// on the rising clock edge; addr and dataIn are valid whenever a strobe is
// high. There is no backpressure: every strobe is accepted on its edge.
// ---------------------------------------------------------------------------
module gpio_expander_regfile #(
    parameter int NUM_PORTS   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             addr,
    input  logic [7:0]             dataIn,
    input  logic                   writeEn,
    input  logic                   rdStrobe,
    output logic [7:0]             dataOut,
    input  logic [8*NUM_PORTS-1:0] gpio_in,
    output logic [8*NUM_PORTS-1:0] gpio_out,
    output logic [8*NUM_PORTS-1:0] gpio_oe,
    output logic                   int_n
);

    localparam int W = 8 * NUM_PORTS;

    logic [SYNC_STAGES-1:0][W-1:0] r_sync;
    logic [W-1:0]                  r_out;
    logic [W-1:0]                  r_pol;
    logic [W-1:0]                  r_cfg;
    logic [W-1:0]                  r_mask;
    logic [W-1:0]                  r_status;
    logic [W-1:0]                  r_ref;
    logic [2:0]                    r_prime_cnt;
    logic                          r_primed;
    logic [7:0]                    r_data_out;
    logic                          r_int_n;

    logic [W-1:0]         w_sync;
    logic [NUM_PORTS-1:0] w_hit_in, w_hit_out, w_hit_pol;
    logic [NUM_PORTS-1:0] w_hit_cfg, w_hit_mask, w_hit_stat;
    logic [7:0]           w_rd_data;
    logic [W-1:0]         w_clr;
    logic [W-1:0]         w_cfg_rise;
    logic [W-1:0]         w_unmask;
    logic [W-1:0]         w_ref_load;
    logic [W-1:0]         w_change;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign gpio_out = r_out;
    assign gpio_oe  = ~r_cfg;
    assign dataOut  = r_data_out;
    assign int_n    = r_int_n;

    // Address decode: one-hot per port for each register bank.
    always_comb begin
        w_hit_in   = '0;
        w_hit_out  = '0;
        w_hit_pol  = '0;
        w_hit_cfg  = '0;
        w_hit_mask = '0;
        w_hit_stat = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_hit_in[p]   = (addr == 8'(p));
            w_hit_out[p]  = (addr == 8'(NUM_PORTS + p));
            w_hit_pol[p]  = (addr == 8'(2 * NUM_PORTS + p));
            w_hit_cfg[p]  = (addr == 8'(3 * NUM_PORTS + p));
            w_hit_mask[p] = (addr == 8'(4 * NUM_PORTS + p));
            w_hit_stat[p] = (addr == 8'(5 * NUM_PORTS + p));
        end
    end

    // Read mux. Uses current register values, so a same-cycle write to the
    // read address shows up in dataOut only on the following read.
    always_comb begin
        w_rd_data = 8'h00;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_hit_in[p])   w_rd_data = w_sync[8*p +: 8] ^ r_pol[8*p +: 8];
            if (w_hit_out[p])  w_rd_data = r_out[8*p +: 8];
            if (w_hit_pol[p])  w_rd_data = r_pol[8*p +: 8];
            if (w_hit_cfg[p])  w_rd_data = r_cfg[8*p +: 8];
            if (w_hit_mask[p]) w_rd_data = r_mask[8*p +: 8];
            if (w_hit_stat[p]) w_rd_data = r_status[8*p +: 8];
        end
    end

    // Per-bit events that re-baseline the reference value:
    //  - read strobe on an input port clears status and absorbs any change
    //  - a bit turning into an input (config 0->1)
    //  - a bit being unmasked (mask 1->0)
    always_comb begin
        w_clr      = '0;
        w_cfg_rise = '0;
        w_unmask   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_clr[8*p +: 8] = {8{rdStrobe & w_hit_in[p]}};
            if (writeEn && w_hit_cfg[p])
                w_cfg_rise[8*p +: 8] = dataIn & ~r_cfg[8*p +: 8];
            if (writeEn && w_hit_mask[p])
                w_unmask[8*p +: 8] = r_mask[8*p +: 8] & ~dataIn;
        end
        w_ref_load = w_clr | w_cfg_rise | w_unmask;
        w_change   = r_cfg & ~r_mask & (w_sync ^ r_ref);
    end

    // Pin synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in};
    end

    // Priming: after reset the synchroniser holds stale zeros, so change
    // detection stays off until SYNC_STAGES+1 edges have flushed it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prime_cnt <= 3'd0;
            r_primed    <= 1'b0;
        end else if (!r_primed) begin
            if (r_prime_cnt == 3'(SYNC_STAGES)) r_primed    <= 1'b1;
            else                                r_prime_cnt <= r_prime_cnt + 3'd1;
        end
    end

    // Writable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '1;
            r_pol  <= '0;
            r_cfg  <= '1;
            r_mask <= '1;
        end else if (writeEn) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_hit_out[p])  r_out[8*p +: 8]  <= dataIn;
                if (w_hit_pol[p])  r_pol[8*p +: 8]  <= dataIn;
                if (w_hit_cfg[p])  r_cfg[8*p +: 8]  <= dataIn;
                if (w_hit_mask[p]) r_mask[8*p +: 8] <= dataIn;
            end
        end
    end

    // Change detection. The clear term is applied after the set term so a
    // change arriving in the clearing cycle is dropped (it is in r_ref now).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref    <= '0;
            r_status <= '0;
        end else if (!r_primed) begin
            r_ref    <= w_sync;
            r_status <= '0;
        end else begin
            r_status <= (r_status | w_change) & ~w_clr;
            r_ref    <= (r_ref & ~w_ref_load) | (w_sync & w_ref_load);
        end
    end

    // Registered read data and interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= 8'h00;
            r_int_n    <= 1'b1;
        end else begin
            r_data_out <= w_rd_data;
            r_int_n    <= ~|r_status;
        end
    end

endmodule

// File: tb/tb_gpio_expander_regfile.sv
// ---------------------------------------------------------------------------
// tb_gpio_expander_regfile
//
// Self-checking bench for gpio_expander_regfile with NUM_PORTS=2,
// SYNC_STAGES=2. Inputs are driven on the falling edge and outputs sampled
// on the falling edge. Expected read data is pushed to exp_q when a read
// address is driven and popped when dataOut becomes valid.
// ---------------------------------------------------------------------------
module tb_gpio_expander_regfile;

    localparam int NP = 2;
    localparam int SS = 2;
    localparam int W  = 8 * NP;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic [7:0]   addr     = 8'h00;
    logic [7:0]   dataIn   = 8'h00;
    logic         writeEn  = 1'b0;
    logic         rdStrobe = 1'b0;
    logic [W-1:0] gpio_in  = '0;
    logic [7:0]   dataOut;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         int_n;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    gpio_expander_regfile #(.NUM_PORTS(NP), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .dataIn(dataIn),
        .writeEn(writeEn), .rdStrobe(rdStrobe), .dataOut(dataOut),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
        .int_n(int_n)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; dataIn = d; writeEn = 1'b1;
        @(negedge clk);
        writeEn = 1'b0;
    endtask

    task automatic strobe_rd(input logic [7:0] a);
        addr = a; rdStrobe = 1'b1;
        @(negedge clk);
        rdStrobe = 1'b0;
    endtask

    task automatic issue_read(input logic [7:0] a, input logic [7:0] expv);
        addr = a;
        exp_q.push_back(expv);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] tbl [13];
        logic [7:0] e;
        tbl = '{8'h3C, 8'h5A, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF,
                8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        gpio_in = 16'h5A3C;
        rst_n   = 1'b0;
        idle(3);
        n_checks++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL rst_dataOut: got %h exp 00", dataOut); end
        n_checks++; if (gpio_out !== 16'hFFFF) begin n_fail++; $display("FAIL rst_gpio_out: got %h exp FFFF", gpio_out); end
        n_checks++; if (gpio_oe !== 16'h0000) begin n_fail++; $display("FAIL rst_gpio_oe: got %h exp 0000", gpio_oe); end
        n_checks++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL rst_int_n: got %b exp 1", int_n); end
        rst_n = 1'b1;
        idle(SS + 3);
        for (int i = 0; i < 13; i++) begin
            issue_read(8'(i), tbl[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (dataOut !== e) begin n_fail++; $display("FAIL reset_map addr %0h: got %h exp %h", i, dataOut, e); end
        end
        n_checks++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL reset_int_n: got %b exp 1", int_n); end
    endtask

    task automatic test_polarity();
        logic [7:0] e;
        gpio_in[7:0] = 8'hA5;
        wr(8'h04, 8'h0F);
        idle(SS + 1);
        issue_read(8'h00, 8'hAA);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL pol_input0: got %h exp %h", dataOut, e); end
        wr(8'h00, 8'h00);
        issue_read(8'h00, 8'hAA);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL input_ro: got %h exp %h", dataOut, e); end
        issue_read(8'h04, 8'h0F);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL pol_readback: got %h exp %h", dataOut, e); end
    endtask

    task automatic test_outputs();
        logic [7:0] e;
        wr(8'h07, 8'h00);
        n_checks++; if (gpio_oe !== 16'hFF00) begin n_fail++; $display("FAIL oe_cfg1: got %h exp FF00", gpio_oe); end
        wr(8'h03, 8'h3C);
        n_checks++; if (gpio_out !== 16'h3CFF) begin n_fail++; $display("FAIL out1: got %h exp 3CFF", gpio_out); end
        // Write and read the same address in one cycle: pre-write value.
        exp_q.push_back(8'h3C);
        wr(8'h03, 8'h55);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL rw_same_cycle: got %h exp %h", dataOut, e); end
        issue_read(8'h03, 8'h55);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL out1_readback: got %h exp %h", dataOut, e); end
        n_checks++; if (gpio_out !== 16'h55FF) begin n_fail++; $display("FAIL out1_pins: got %h exp 55FF", gpio_out); end
    endtask

    task automatic test_change_detect();
        logic [7:0] e;
        bit found;
        wr(8'h08, 8'hFE);
        gpio_in[0] = ~gpio_in[0];
        found = 1'b0;
        for (int c = 0; c < SS + 2 && !found; c++) begin
            @(negedge clk);
            if (int_n === 1'b0) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL int_assert: got int_n=%b exp 0 within %0d cycles", int_n, SS + 2); end
        issue_read(8'h0A, 8'h01);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL status_set: got %h exp %h", dataOut, e); end
        // Masked bit toggles: no new status.
        gpio_in[1] = ~gpio_in[1];
        idle(SS + 3);
        issue_read(8'h0A, 8'h01);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL masked_bit: got %h exp %h", dataOut, e); end
        // Read strobe on a non-input address does nothing.
        strobe_rd(8'h0A);
        idle(2);
        issue_read(8'h0A, 8'h01);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL strobe_non_input: got %h exp %h", dataOut, e); end
        // Pin returning to its reference value does not clear status.
        gpio_in[0] = ~gpio_in[0];
        idle(SS + 3);
        issue_read(8'h0A, 8'h01);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL sticky_status: got %h exp %h", dataOut, e); end
        n_checks++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL sticky_int: got %b exp 0", int_n); end
        // Clear by read strobe at input port 0.
        strobe_rd(8'h00);
        n_checks++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL int_registered: got %b exp 0", int_n); end
        issue_read(8'h0A, 8'h00);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL status_clear: got %h exp %h", dataOut, e); end
        n_checks++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL int_release: got %b exp 1", int_n); end
    endtask

    task automatic test_clear_race();
        logic [7:0] e;
        gpio_in[0] = ~gpio_in[0];
        idle(SS);
        strobe_rd(8'h00);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (int_n !== 1'b1) begin n_fail++; $display("FAIL race_int cycle %0d: got %b exp 1", c, int_n); end
            @(negedge clk);
        end
        issue_read(8'h0A, 8'h00);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL race_status: got %h exp %h", dataOut, e); end
    endtask

    task automatic test_reset_priming();
        logic [7:0] e;
        // Build non-reset state: pending interrupt, port 1 driven.
        gpio_in[0] = ~gpio_in[0];
        idle(SS + 3);
        addr = 8'h03;
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL async_dataOut: got %h exp 00", dataOut); end
        n_checks++; if (gpio_out !== 16'hFFFF) begin n_fail++; $display("FAIL async_gpio_out: got %h exp FFFF", gpio_out); end
        n_checks++; if (gpio_oe !== 16'h0000) begin n_fail++; $display("FAIL async_gpio_oe: got %h exp 0000", gpio_oe); end
        n_checks++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL async_int_n: got %b exp 1", int_n); end
        gpio_in[0] = 1'b0;
        idle(2);
        // Release, then toggle pin 0 and unmask it in the first cycle.
        rst_n = 1'b1;
        gpio_in[0] = 1'b1;
        #1;
        n_checks++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL release_dataOut: got %h exp 00", dataOut); end
        wr(8'h08, 8'hFE);
        idle(SS + 4);
        issue_read(8'h0A, 8'h00);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL priming_status: got %h exp %h", dataOut, e); end
        n_checks++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL priming_int: got %b exp 1", int_n); end
        issue_read(8'h03, 8'hFF);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL post_reset_out1: got %h exp %h", dataOut, e); end
        // Detection is live once primed.
        gpio_in[0] = 1'b0;
        idle(SS + 3);
        issue_read(8'h0A, 8'h01);
        e = exp_q.pop_front(); n_checks++;
        if (dataOut !== e) begin n_fail++; $display("FAIL primed_detect: got %h exp %h", dataOut, e); end
        n_checks++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL primed_int: got %b exp 0", int_n); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_polarity();
        test_outputs();
        test_change_detect();
        test_clear_race();
        test_reset_priming();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
